// File: rtl/pio_fifo.sv
// TX/RX FIFO pair between the host bus and one PIO state machine, with sticky error flags.
// Defining PIO_FIFO_JOIN_EN compiles in joining both FIFOs into a single FIFO of 2*DEPTH entries.
module pio_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
`ifdef PIO_FIFO_JOIN_EN
    localparam int LW = $clog2(2 * DEPTH) + 1
`else
    localparam int LW = $clog2(DEPTH) + 1
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_wr,
    input  logic [WIDTH-1:0] tx_wdata,
    input  logic             rx_rd,
    output logic [WIDTH-1:0] rx_rdata,
    input  logic             pull,
    output logic [WIDTH-1:0] pull_data,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             empty,
    output logic             full,
    output logic             tx_full,
    output logic             rx_empty,
    output logic [LW-1:0]    tx_level,
    output logic [LW-1:0]    rx_level,
    input  logic [3:0]       flag_clr,
    output logic [3:0]       flags
`ifdef PIO_FIFO_JOIN_EN
    ,
    input  logic             join_tx,
    input  logic             join_rx
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int MAW = AW + 1;
    localparam logic [LW-1:0] CAP_N = LW'(DEPTH);
    localparam logic [LW-1:0] LIM_N = LW'(2 * DEPTH - 1);
    localparam logic [LW-1:0] MSK_N = LW'(DEPTH - 1);
`ifdef PIO_FIFO_JOIN_EN
    localparam logic [LW-1:0] CAP_J = LW'(2 * DEPTH);
    localparam logic [LW-1:0] LIM_J = LW'(4 * DEPTH - 1);
    localparam logic [LW-1:0] MSK_J = LW'(2 * DEPTH - 1);
`endif

    // Shared storage: TX owns the lower half, RX the upper half, unless joined.
    logic [WIDTH-1:0] mem_r [0:2*DEPTH-1];

    logic [LW-1:0]  tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
    logic [LW-1:0]  tx_wp_n_s, tx_rp_n_s, rx_wp_n_s, rx_rp_n_s;
    logic [LW-1:0]  tx_cap_s, tx_lim_s, tx_msk_s, rx_cap_s, rx_lim_s, rx_msk_s;
    logic [LW-1:0]  tx_lvl_s, rx_lvl_s, tx_lvl_n_s, rx_lvl_n_s;
    logic [LW-1:0]  tx_level_r, rx_level_r;
    logic [MAW-1:0] tx_wa_s, tx_ra_s, rx_wa_s, rx_ra_s, rx_base_s;
    logic [1:0]     mode_s, mode_r;
    logic [3:0]     flag_set_s, flags_r;
    logic           flush_s, tx_act_s, rx_act_s;
    logic           tx_is_empty_s, tx_is_full_s, rx_is_empty_s, rx_is_full_s;
    logic           tx_do_wr_s, tx_do_pop_s, rx_do_wr_s, rx_do_pop_s;
    logic           empty_n_s, full_n_s, tx_full_n_s, rx_empty_n_s;
    logic           empty_r, full_r, tx_full_r, rx_empty_r;

    // Wrap a pointer back to zero after it reaches 2*capacity-1.
    function automatic logic [LW-1:0] ptr_inc(input logic [LW-1:0] p, input logic [LW-1:0] lim);
        if (p == lim) begin
            ptr_inc = {LW{1'b0}};
        end else begin
            ptr_inc = p + {{(LW-1){1'b0}}, 1'b1};
        end
    endfunction

`ifdef PIO_FIFO_JOIN_EN
    // Both join requests together fall back to the unjoined layout.
    assign mode_s = {join_rx & ~join_tx, join_tx & ~join_rx};
`else
    assign mode_s = 2'b00;
`endif

    // Active capacity, pointer wrap limit and index mask of each FIFO.
    always_comb begin
        tx_cap_s = CAP_N;
        tx_lim_s = LIM_N;
        tx_msk_s = MSK_N;
        rx_cap_s = CAP_N;
        rx_lim_s = LIM_N;
        rx_msk_s = MSK_N;
`ifdef PIO_FIFO_JOIN_EN
        if (mode_r[0]) begin
            tx_cap_s = CAP_J;
            tx_lim_s = LIM_J;
            tx_msk_s = MSK_J;
        end else begin
            tx_cap_s = CAP_N;
            tx_lim_s = LIM_N;
            tx_msk_s = MSK_N;
        end
        if (mode_r[1]) begin
            rx_cap_s = CAP_J;
            rx_lim_s = LIM_J;
            rx_msk_s = MSK_J;
        end else begin
            rx_cap_s = CAP_N;
            rx_lim_s = LIM_N;
            rx_msk_s = MSK_N;
        end
`endif
    end

    // Strobe qualification, error detection and next pointer/status values.
    always_comb begin
        flush_s  = (mode_s != mode_r);
        tx_act_s = ~reset & ~flush_s & ~mode_r[1];
        rx_act_s = ~reset & ~flush_s & ~mode_r[0];

        tx_lvl_s      = (tx_wp_r - tx_rp_r) & tx_lim_s;
        rx_lvl_s      = (rx_wp_r - rx_rp_r) & rx_lim_s;
        tx_is_empty_s = (tx_lvl_s == {LW{1'b0}});
        tx_is_full_s  = (tx_lvl_s == tx_cap_s);
        rx_is_empty_s = (rx_lvl_s == {LW{1'b0}});
        rx_is_full_s  = (rx_lvl_s == rx_cap_s);

        tx_do_wr_s  = tx_act_s & tx_wr & ~tx_is_full_s;
        tx_do_pop_s = tx_act_s & pull & ~tx_is_empty_s;
        rx_do_wr_s  = rx_act_s & push & ~rx_is_full_s;
        rx_do_pop_s = rx_act_s & rx_rd & ~rx_is_empty_s;

        // A pop on an empty FIFO with a simultaneous write is absorbed, not flagged.
        flag_set_s = {rx_act_s & rx_rd & rx_is_empty_s & ~push,
                      rx_act_s & push & rx_is_full_s,
                      tx_act_s & tx_wr & tx_is_full_s,
                      tx_act_s & pull & tx_is_empty_s & ~tx_wr};

        rx_base_s = mode_r[1] ? {MAW{1'b0}} : MAW'(DEPTH);
        tx_wa_s   = MAW'(tx_wp_r & tx_msk_s);
        tx_ra_s   = MAW'(tx_rp_r & tx_msk_s);
        rx_wa_s   = MAW'(rx_wp_r & rx_msk_s) + rx_base_s;
        rx_ra_s   = MAW'(rx_rp_r & rx_msk_s) + rx_base_s;

        if (flush_s) begin
            tx_wp_n_s = {LW{1'b0}};
            tx_rp_n_s = {LW{1'b0}};
            rx_wp_n_s = {LW{1'b0}};
            rx_rp_n_s = {LW{1'b0}};
        end else begin
            tx_wp_n_s = tx_do_wr_s  ? ptr_inc(tx_wp_r, tx_lim_s) : tx_wp_r;
            tx_rp_n_s = tx_do_pop_s ? ptr_inc(tx_rp_r, tx_lim_s) : tx_rp_r;
            rx_wp_n_s = rx_do_wr_s  ? ptr_inc(rx_wp_r, rx_lim_s) : rx_wp_r;
            rx_rp_n_s = rx_do_pop_s ? ptr_inc(rx_rp_r, rx_lim_s) : rx_rp_r;
        end

        tx_lvl_n_s   = (tx_wp_n_s - tx_rp_n_s) & tx_lim_s;
        rx_lvl_n_s   = (rx_wp_n_s - rx_rp_n_s) & rx_lim_s;
        empty_n_s    = (tx_lvl_n_s == {LW{1'b0}}) | mode_s[1];
        tx_full_n_s  = (tx_lvl_n_s == tx_cap_s) | mode_s[1];
        rx_empty_n_s = (rx_lvl_n_s == {LW{1'b0}}) | mode_s[0];
        full_n_s     = (rx_lvl_n_s == rx_cap_s) | mode_s[0];
    end

    // Pointer, join mode, status and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_r    <= {LW{1'b0}};
            tx_rp_r    <= {LW{1'b0}};
            rx_wp_r    <= {LW{1'b0}};
            rx_rp_r    <= {LW{1'b0}};
            mode_r     <= mode_s;
            tx_level_r <= {LW{1'b0}};
            rx_level_r <= {LW{1'b0}};
            empty_r    <= 1'b1;
            rx_empty_r <= 1'b1;
            full_r     <= 1'b0;
            tx_full_r  <= 1'b0;
            flags_r    <= 4'b0000;
        end else begin
            tx_wp_r    <= tx_wp_n_s;
            tx_rp_r    <= tx_rp_n_s;
            rx_wp_r    <= rx_wp_n_s;
            rx_rp_r    <= rx_rp_n_s;
            mode_r     <= mode_s;
            tx_level_r <= tx_lvl_n_s;
            rx_level_r <= rx_lvl_n_s;
            empty_r    <= empty_n_s;
            rx_empty_r <= rx_empty_n_s;
            full_r     <= full_n_s;
            tx_full_r  <= tx_full_n_s;
            flags_r    <= (flags_r & ~flag_clr) | flag_set_s;
        end
    end

    // Storage writes; contents survive reset and are discarded via the pointers.
    always_ff @(posedge clk) begin
        if (tx_do_wr_s) begin
            mem_r[tx_wa_s] <= tx_wdata;
        end
        if (rx_do_wr_s) begin
            mem_r[rx_wa_s] <= push_data;
        end
    end

    assign pull_data = mem_r[tx_ra_s];
    assign rx_rdata  = mem_r[rx_ra_s];
    assign empty     = empty_r;
    assign full      = full_r;
    assign tx_full   = tx_full_r;
    assign rx_empty  = rx_empty_r;
    assign tx_level  = tx_level_r;
    assign rx_level  = rx_level_r;
    assign flags     = flags_r;

endmodule

// File: tb/tb_pio_fifo.sv
// Self-checking bench for pio_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_pio_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
`ifdef PIO_FIFO_JOIN_EN
    localparam int LW = $clog2(2 * DEPTH) + 1;
`else
    localparam int LW = $clog2(DEPTH) + 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tx_wr = 1'b0;
    logic [WIDTH-1:0] tx_wdata = '0;
    logic             rx_rd = 1'b0;
    logic [WIDTH-1:0] rx_rdata;
    logic             pull = 1'b0;
    logic [WIDTH-1:0] pull_data;
    logic             push = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic             empty, full, tx_full, rx_empty;
    logic [LW-1:0]    tx_level, rx_level;
    logic [3:0]       flag_clr = 4'b0000;
    logic [3:0]       flags;
`ifdef PIO_FIFO_JOIN_EN
    logic             join_tx = 1'b0;
    logic             join_rx = 1'b0;
`endif

    pio_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .tx_wr(tx_wr), .tx_wdata(tx_wdata),
        .rx_rd(rx_rd), .rx_rdata(rx_rdata),
        .pull(pull), .pull_data(pull_data),
        .push(push), .push_data(push_data),
        .empty(empty), .full(full), .tx_full(tx_full), .rx_empty(rx_empty),
        .tx_level(tx_level), .rx_level(rx_level),
        .flag_clr(flag_clr), .flags(flags)
`ifdef PIO_FIFO_JOIN_EN
        , .join_tx(join_tx), .join_rx(join_rx)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain queues and a flag word, updated from the documented rules.
    logic [WIDTH-1:0] tx_q[$];
    logic [WIDTH-1:0] rx_q[$];
    logic [3:0]       m_flags = 4'b0000;

    task automatic cycle();
        bit tf, te, rf, re;
        logic [3:0] set;
        @(posedge clk);
        if (reset) begin
            tx_q.delete();
            rx_q.delete();
            m_flags = 4'b0000;
        end else begin
            tf = (tx_q.size() == DEPTH);
            te = (tx_q.size() == 0);
            rf = (rx_q.size() == DEPTH);
            re = (rx_q.size() == 0);
            set = 4'b0000;
            if (tx_wr && tf) set[1] = 1'b1;
            if (pull && te && !tx_wr) set[0] = 1'b1;
            if (push && rf) set[2] = 1'b1;
            if (rx_rd && re && !push) set[3] = 1'b1;
            if (pull && !te) void'(tx_q.pop_front());
            if (tx_wr && !tf) tx_q.push_back(tx_wdata);
            if (rx_rd && !re) void'(rx_q.pop_front());
            if (push && !rf) rx_q.push_back(push_data);
            m_flags = (m_flags & ~flag_clr) | set;
        end
        #1;
    endtask

    task automatic idle();
        tx_wr = 1'b0; pull = 1'b0; push = 1'b0; rx_rd = 1'b0; flag_clr = 4'b0000;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic tx_write(input logic [WIDTH-1:0] d);
        tx_wr = 1'b1; tx_wdata = d;
        cycle();
        tx_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (tx_full !== 1'b0) begin n_bad++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
        n_cmp++; if (tx_level !== LW'(0) || rx_level !== LW'(0)) begin
            n_bad++; $display("FAIL reset_levels: got %0d/%0d want 0/0", tx_level, rx_level);
        end
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] d[4];
        d = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_reset();
        for (int i = 0; i < 4; i++) tx_write(d[i]);
        n_cmp++; if (tx_full !== 1'b1) begin n_bad++; $display("FAIL fill_tx_full: got %b want 1", tx_full); end
        n_cmp++; if (tx_level !== LW'(4)) begin n_bad++; $display("FAIL fill_level: got %0d want 4", tx_level); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pull_data !== d[i]) begin
                n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, pull_data, d[i]);
            end
            pull = 1'b1; cycle(); pull = 1'b0;
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_write_pull();
        logic [WIDTH-1:0] d[4];
        d = '{32'h22, 32'h33, 32'h44, 32'h66};
        do_reset();
        tx_write(32'h11); tx_write(32'h22); tx_write(32'h33); tx_write(32'h44);
        tx_wr = 1'b1; tx_wdata = 32'h55; pull = 1'b1;
        cycle(); idle();
        n_cmp++; if (pull_data !== 32'h22) begin n_bad++; $display("FAIL fullwp_head: got %h want 22", pull_data); end
        n_cmp++; if (flags[1] !== 1'b1) begin n_bad++; $display("FAIL fullwp_tx_over: got %b want 1", flags[1]); end
        n_cmp++; if (tx_level !== LW'(3)) begin n_bad++; $display("FAIL fullwp_level: got %0d want 3", tx_level); end
        flag_clr = 4'b0010; cycle(); idle();
        n_cmp++; if (flags[1] !== 1'b0) begin n_bad++; $display("FAIL clr_tx_over: got %b want 0", flags[1]); end
        tx_write(32'h66);
        // overflow in the same cycle as the clear: set must win
        tx_wr = 1'b1; tx_wdata = 32'h77; flag_clr = 4'b0010;
        cycle(); idle();
        n_cmp++; if (flags !== 4'b0010) begin n_bad++; $display("FAIL set_wins: got %b want 0010", flags); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pull_data !== d[i]) begin
                n_bad++; $display("FAIL fullwp_order[%0d]: got %h want %h", i, pull_data, d[i]);
            end
            pull = 1'b1; cycle(); pull = 1'b0;
        end
    endtask

    task automatic test_empty_write_pull();
        do_reset();
        tx_wr = 1'b1; tx_wdata = 32'hA5; pull = 1'b1;
        cycle(); idle();
        n_cmp++; if (tx_level !== LW'(1)) begin n_bad++; $display("FAIL emptywp_level: got %0d want 1", tx_level); end
        n_cmp++; if (pull_data !== 32'hA5) begin n_bad++; $display("FAIL emptywp_data: got %h want a5", pull_data); end
        n_cmp++; if (flags[0] !== 1'b0) begin n_bad++; $display("FAIL emptywp_stall: got %b want 0", flags[0]); end
        pull = 1'b1; cycle();
        cycle(); idle();
        n_cmp++; if (flags !== 4'b0001 || tx_level !== LW'(0)) begin
            n_bad++; $display("FAIL pull_empty_stall: got flags %b level %0d want 0001 0", flags, tx_level);
        end
    endtask

    task automatic test_rx();
        do_reset();
        push = 1'b1; push_data = 32'hDEADBEEF; cycle(); idle();
        n_cmp++; if (rx_empty !== 1'b0 || rx_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rx_first: got empty %b data %h want 0 deadbeef", rx_empty, rx_rdata);
        end
        rx_rd = 1'b1; cycle();
        n_cmp++; if (rx_empty !== 1'b1 || flags[3] !== 1'b0) begin
            n_bad++; $display("FAIL rx_read1: got empty %b under %b want 1 0", rx_empty, flags[3]);
        end
        cycle(); idle();
        n_cmp++; if (rx_empty !== 1'b1 || flags[3] !== 1'b1) begin
            n_bad++; $display("FAIL rx_under: got empty %b under %b want 1 1", rx_empty, flags[3]);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            push = 1'b1; push_data = WIDTH'(i + 1); cycle();
        end
        idle();
        n_cmp++; if (full !== 1'b1 || flags[2] !== 1'b1 || rx_level !== LW'(DEPTH) || rx_rdata !== 32'd1) begin
            n_bad++; $display("FAIL rx_over: got full %b over %b level %0d head %h want 1 1 %0d 1",
                              full, flags[2], rx_level, rx_rdata, DEPTH);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tx_write(WIDTH'(i));
            n_cmp++; if (tx_level !== LW'(1) || pull_data !== WIDTH'(i)) begin
                n_bad++; $display("FAIL wrap_write[%0d]: got level %0d data %h want 1 %h", i, tx_level, pull_data, i);
            end
            pull = 1'b1; cycle(); pull = 1'b0;
            n_cmp++; if (tx_level !== LW'(0)) begin
                n_bad++; $display("FAIL wrap_pull[%0d]: got level %0d want 0", i, tx_level);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tx_wr = ($urandom_range(0, 99) < 55);
            pull  = ($urandom_range(0, 99) < 45);
            push  = ($urandom_range(0, 99) < 55);
            rx_rd = ($urandom_range(0, 99) < 45);
            tx_wdata  = $urandom;
            push_data = $urandom;
            flag_clr  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cycle();
            n_cmp++; if (empty !== (tx_q.size() == 0) || tx_full !== (tx_q.size() == DEPTH) ||
                         tx_level !== LW'(tx_q.size())) begin
                n_bad++; $display("FAIL rnd_tx_status[%0d]: got e%b f%b l%0d want level %0d", c, empty, tx_full, tx_level, tx_q.size());
            end
            n_cmp++; if (rx_empty !== (rx_q.size() == 0) || full !== (rx_q.size() == DEPTH) ||
                         rx_level !== LW'(rx_q.size())) begin
                n_bad++; $display("FAIL rnd_rx_status[%0d]: got e%b f%b l%0d want level %0d", c, rx_empty, full, rx_level, rx_q.size());
            end
            n_cmp++; if (flags !== m_flags) begin
                n_bad++; $display("FAIL rnd_flags[%0d]: got %b want %b", c, flags, m_flags);
            end
            if (tx_q.size() != 0) begin
                n_cmp++; if (pull_data !== tx_q[0]) begin
                    n_bad++; $display("FAIL rnd_pull_data[%0d]: got %h want %h", c, pull_data, tx_q[0]);
                end
            end
            if (rx_q.size() != 0) begin
                n_cmp++; if (rx_rdata !== rx_q[0]) begin
                    n_bad++; $display("FAIL rnd_rx_rdata[%0d]: got %h want %h", c, rx_rdata, rx_q[0]);
                end
            end
        end
        idle();
    endtask

`ifdef PIO_FIFO_JOIN_EN
    task automatic test_join();
        do_reset();
        join_tx = 1'b1;
        tx_wr = 1'b1; tx_wdata = 32'hBAD;
        cycle(); idle();
        n_cmp++; if (tx_level !== LW'(0) || full !== 1'b1 || rx_empty !== 1'b1) begin
            n_bad++; $display("FAIL join_flush: got level %0d full %b rx_empty %b want 0 1 1", tx_level, full, rx_empty);
        end
        for (int i = 0; i < 2 * DEPTH; i++) tx_write(WIDTH'(100 + i));
        n_cmp++; if (tx_level !== LW'(2 * DEPTH) || tx_full !== 1'b1 || full !== 1'b1) begin
            n_bad++; $display("FAIL join_fill: got level %0d tx_full %b full %b want %0d 1 1", tx_level, tx_full, full, 2 * DEPTH);
        end
        for (int i = 0; i < 2 * DEPTH; i++) begin
            n_cmp++; if (pull_data !== WIDTH'(100 + i)) begin
                n_bad++; $display("FAIL join_order[%0d]: got %h want %h", i, pull_data, 100 + i);
            end
            pull = 1'b1; cycle(); pull = 1'b0;
        end
        for (int i = 0; i < 3; i++) tx_write(WIDTH'(i));
        join_tx = 1'b0;
        cycle();
        n_cmp++; if (empty !== 1'b1 || tx_level !== LW'(0) || rx_empty !== 1'b1 || full !== 1'b0) begin
            n_bad++; $display("FAIL unjoin_flush: got empty %b level %0d rx_empty %b full %b want 1 0 1 0",
                              empty, tx_level, rx_empty, full);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_full_write_pull();
        test_empty_write_pull();
        test_rx();
        test_wrap();
        test_random();
`ifdef PIO_FIFO_JOIN_EN
        test_join();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
